// File: rtl/reg_file_mp.sv
// reg_file_mp: naiveCPU register file (R0-R7, IH, SP, RA, T flag) with 3 read ports, 1 write port and a debug scan stream.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module reg_file_mp #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_idx_s,
  input  logic [ADDR_W-1:0] rd_idx_t,
  input  logic [ADDR_W-1:0] rd_idx_m,
  output logic [DATA_W-1:0] rd_data_s,
  output logic [DATA_W-1:0] rd_data_t,
  output logic [DATA_W-1:0] rd_data_m,
  input  logic              we_n,
  input  logic [ADDR_W-1:0] wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              t_we_n,
  input  logic              t_in,
  output logic              t_out,
  input  logic              dbg_start,
  output logic              dbg_valid,
  input  logic              dbg_ready,
  output logic [ADDR_W-1:0] dbg_idx,
  output logic [DATA_W-1:0] dbg_data,
  output logic              dbg_t,
  output logic              dbg_done
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} scanState_t;
  scanState_t state, nextState;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic tFlag;
  logic accept;
  logic lastBeat;

  function automatic logic inRange(input logic [ADDR_W-1:0] idx);
    return 32'(idx) < NUM_REGS;
  endfunction

  function automatic logic [DATA_W-1:0] stored(input logic [ADDR_W-1:0] idx);
    return inRange(idx) ? regs[idx] : '0;
  endfunction

`ifdef REGFILE_BYPASS_EN
  function automatic logic [DATA_W-1:0] readPort(input logic [ADDR_W-1:0] idx);
    return (!we_n && idx == wr_idx && inRange(wr_idx)) ? wr_data : stored(idx);
  endfunction
  assign t_out = t_we_n ? tFlag : t_in;
`else
  function automatic logic [DATA_W-1:0] readPort(input logic [ADDR_W-1:0] idx);
    return stored(idx);
  endfunction
  assign t_out = tFlag;
`endif

  assign accept   = dbg_valid && dbg_ready;
  assign lastBeat = 32'(dbg_idx) == NUM_REGS - 1;

  // combinational read ports; the scan stream always sees stored values
  always_comb begin
    rd_data_s = readPort(rd_idx_s);
    rd_data_t = readPort(rd_idx_t);
    rd_data_m = readPort(rd_idx_m);
    dbg_data  = stored(dbg_idx);
    dbg_t     = tFlag;
  end

  // register array write; out-of-range indices are silently dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (!we_n && inRange(wr_idx)) begin
      regs[wr_idx] <= wr_data;
    end
  end

  // T flag write, independent of the register write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tFlag <= 1'b0;
    else if (!t_we_n) tFlag <= t_in;
  end

  // scan state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= nextState;
  end

  // scan next-state: start only from IDLE, finish after the last accepted beat
  always_comb begin
    nextState = (state == IDLE && dbg_start)         ? SCAN :
                (state == SCAN && accept && lastBeat) ? DONE :
                (state == DONE)                       ? IDLE : state;
  end

  // scan outputs decoded from state
  always_comb begin
    dbg_valid = state == SCAN;
    dbg_done  = state == DONE;
  end

  // scan index: cleared on start, advanced on each accepted beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dbg_idx <= '0;
    else if (state == IDLE && dbg_start) dbg_idx <= '0;
    else if (accept) dbg_idx <= dbg_idx + 1'b1;
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: randomized self-checking bench for reg_file_mp against a behavioural model.
module tb_reg_file_mp;
  logic clk = 0;
  logic rst;
  logic [3:0] rd_idx_s, rd_idx_t, rd_idx_m, wr_idx, dbg_idx;
  logic [15:0] rd_data_s, rd_data_t, rd_data_m, wr_data, dbg_data;
  logic we_n, t_we_n, t_in, t_out, dbg_start, dbg_valid, dbg_ready, dbg_t, dbg_done;

  int checks = 0;
  int failures = 0;
  logic [15:0] mem [16];
  logic tModel;
  bit scanActive, doneDue;
  int scanNext;
  int beatCount, doneCount;

  reg_file_mp dut (
    .clk(clk), .rst(rst),
    .rd_idx_s(rd_idx_s), .rd_idx_t(rd_idx_t), .rd_idx_m(rd_idx_m),
    .rd_data_s(rd_data_s), .rd_data_t(rd_data_t), .rd_data_m(rd_data_m),
    .we_n(we_n), .wr_idx(wr_idx), .wr_data(wr_data),
    .t_we_n(t_we_n), .t_in(t_in), .t_out(t_out),
    .dbg_start(dbg_start), .dbg_valid(dbg_valid), .dbg_ready(dbg_ready),
    .dbg_idx(dbg_idx), .dbg_data(dbg_data), .dbg_t(dbg_t), .dbg_done(dbg_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] expRead(input logic [3:0] idx);
    logic [15:0] v;
    v = idx < 11 ? mem[idx] : 16'h0;
`ifdef REGFILE_BYPASS_EN
    if (!we_n && wr_idx < 11 && idx == wr_idx) v = wr_data;
`endif
    return v;
  endfunction

  function automatic logic expT();
`ifdef REGFILE_BYPASS_EN
    if (!t_we_n) return t_in;
`endif
    return tModel;
  endfunction

  task automatic checkOutputs();
    chk("rd_s", rd_data_s, expRead(rd_idx_s));
    chk("rd_t", rd_data_t, expRead(rd_idx_t));
    chk("rd_m", rd_data_m, expRead(rd_idx_m));
    chk("t_out", t_out, expT());
    chk("dbg_valid", dbg_valid, scanActive);
    chk("dbg_done", dbg_done, doneDue);
    if (scanActive) begin
      chk("dbg_idx", dbg_idx, scanNext);
      chk("dbg_data", dbg_data, mem[scanNext]);
      chk("dbg_t", dbg_t, tModel);
    end
    beatCount += int'(dbg_valid && dbg_ready);
    doneCount += int'(dbg_done);
  endtask

  task automatic updateModel();
    if (scanActive && dbg_ready) begin
      scanNext++;
      if (scanNext == 11) begin
        scanActive = 0;
        doneDue = 1;
      end
    end else if (doneDue) doneDue = 0;
    else if (!scanActive && dbg_start) begin
      scanActive = 1;
      scanNext = 0;
    end
    if (!we_n && wr_idx < 11) mem[wr_idx] = wr_data;
    if (!t_we_n) tModel = t_in;
  endtask

  task automatic step();
    @(negedge clk);
    checkOutputs();
    @(posedge clk);
    updateModel();
    #1;
  endtask

  task automatic idleIns();
    we_n = 1; t_we_n = 1; t_in = 0; dbg_start = 0; dbg_ready = 0;
    wr_idx = 0; wr_data = 0;
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) mem[i] = 16'h0;
    tModel = 0; scanActive = 0; doneDue = 0; scanNext = 0;
  endtask

  task automatic applyReset();
    idleIns();
    rst = 0;
    #2;
    chk("rst_valid", dbg_valid, 0);
    chk("rst_done", dbg_done, 0);
    chk("rst_idx", dbg_idx, 0);
    chk("rst_tout", t_out, 0);
    for (int i = 0; i < 16; i++) begin
      rd_idx_s = 4'(i); rd_idx_t = 4'(i); rd_idx_m = 4'(i);
      #1;
      chk("rst_rd_s", rd_data_s, 0);
      chk("rst_rd_t", rd_data_t, 0);
      chk("rst_rd_m", rd_data_m, 0);
    end
    modelReset();
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic randIns(input bit allowWrite, input int startPct);
    we_n = allowWrite ? $urandom_range(0, 1) == 0 : 1'b1;
    wr_idx = 4'($urandom_range(0, 15));
    wr_data = 16'($urandom);
    t_we_n = $urandom_range(0, 2) != 0;
    t_in = 1'($urandom);
    rd_idx_s = 4'($urandom_range(0, 15));
    rd_idx_t = 4'($urandom_range(0, 15));
    rd_idx_m = 4'($urandom_range(0, 15));
    dbg_ready = 1'($urandom);
    dbg_start = $urandom_range(0, 99) < startPct;
  endtask

  task automatic runScan(input string tag, input bit toggleReady, input bit writes);
    beatCount = 0; doneCount = 0;
    dbg_start = 1; dbg_ready = 1;
    step();
    for (int c = 0; c < 100 && (scanActive || doneDue); c++) begin
      if (writes) randIns(1, 0);
      dbg_ready = toggleReady ? c[0] : 1'b1;
      dbg_start = (c == 6);
      step();
    end
    idleIns();
    step();
    chk({tag, "_beats"}, beatCount, 11);
    chk({tag, "_dones"}, doneCount, 1);
    chk({tag, "_idle"}, dbg_valid, 0);
  endtask

  initial begin
    idleIns();
    rd_idx_s = 0; rd_idx_t = 0; rd_idx_m = 0;
    modelReset();
    rst = 0;
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    // reset clears everything
    for (int i = 0; i < 11; i++) begin
      we_n = 0; wr_idx = 4'(i); wr_data = 16'hFFFF; t_we_n = 0; t_in = 1;
      step();
    end
    idleIns();
    step();
    applyReset();
    // write SP, read on all ports; out-of-range write ignored
    we_n = 0; wr_idx = 9; wr_data = 16'hBF00;
    step();
    we_n = 1; rd_idx_s = 9; rd_idx_t = 9; rd_idx_m = 9;
    step();
    chk("sp_s", rd_data_s, 16'hBF00);
    chk("sp_t", rd_data_t, 16'hBF00);
    chk("sp_m", rd_data_m, 16'hBF00);
    we_n = 0; wr_idx = 12; wr_data = 16'hDEAD;
    step();
    we_n = 1; rd_idx_s = 12;
    step();
    chk("oob_rd", rd_data_s, 0);
    // same-cycle write and read
    we_n = 0; wr_idx = 3; wr_data = 16'h0055;
    step();
    wr_data = 16'h1234; rd_idx_s = 3;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_same", rd_data_s, 16'h1234);
`else
    chk("byp_same", rd_data_s, 16'h0055);
`endif
    step();
    we_n = 1;
    step();
    chk("byp_next", rd_data_s, 16'h1234);
    // directed scan of known contents
    for (int i = 0; i < 11; i++) begin
      we_n = 0; wr_idx = 4'(i); wr_data = 16'h100 + 16'(i);
      step();
    end
    idleIns();
    runScan("scan_full", 0, 0);
    // stalls, concurrent writes and an ignored mid-scan start
    runScan("scan_stall", 1, 1);
    // reset in the middle of a scan
    doneCount = 0;
    dbg_start = 1; dbg_ready = 1;
    step();
    dbg_start = 0;
    for (int c = 0; c < 20 && scanNext < 5; c++) step();
    chk("mid_idx", dbg_idx, 5);
    applyReset();
    for (int c = 0; c < 4; c++) step();
    chk("mid_nodone", doneCount, 0);
    dbg_start = 1; dbg_ready = 0;
    step();
    dbg_start = 0;
    chk("restart_idx", dbg_idx, 0);
    chk("restart_valid", dbg_valid, 1);
    // random traffic
    for (int c = 0; c < 400; c++) begin
      randIns(1, 5);
      step();
    end
    idleIns();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
